// File: rtl/soc_shared_mem_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : soc_shared_mem_arb_if
//  Purpose  : Bus bundle between the requester ports, the shared-memory
//             arbiter and the single-ported SRAM.
//  Signals  : req_i/gnt_o/addr_i/we_i/wdata_i/strb_i   requester side
//             rvalid_o/rdata_o/err_o                    response side
//             mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_wmask_o/
//             mem_rdata_i                               SRAM side
//  Modports : slave  - the arbiter
//             master - requesters plus SRAM (environment)
//  Revision : 1.0  initial release
// ============================================================================
interface soc_shared_mem_arb_if #(
    parameter int NumPorts = 2,
    parameter int Width    = 32,
    parameter int AW       = 20
);
    logic [NumPorts-1:0]             req_i;
    logic [NumPorts-1:0]             gnt_o;
    logic [NumPorts-1:0][31:0]       addr_i;
    logic [NumPorts-1:0]             we_i;
    logic [NumPorts-1:0][Width-1:0]  wdata_i;
    logic [NumPorts-1:0][Width-1:0]  strb_i;
    logic [NumPorts-1:0]             rvalid_o;
    logic [NumPorts-1:0][Width-1:0]  rdata_o;
    logic [NumPorts-1:0]             err_o;
    logic                            mem_req_o;
    logic                            mem_we_o;
    logic [AW-1:0]                   mem_addr_o;
    logic [Width-1:0]                mem_wdata_o;
    logic [Width-1:0]                mem_wmask_o;
    logic [Width-1:0]                mem_rdata_i;

    modport slave (
        input  req_i, addr_i, we_i, wdata_i, strb_i, mem_rdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o
    );

    modport master (
        output req_i, addr_i, we_i, wdata_i, strb_i, mem_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o
    );
endinterface
`default_nettype wire

// File: rtl/soc_shared_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : soc_shared_mem_arb
//  Purpose  : Round-robin arbiter in front of one single-ported SRAM.
//             Relocates byte addresses to SRAM word indices, rejects
//             out-of-range accesses with an error response, and returns
//             in-order responses Latency cycles after each grant.
//  Ports    : clk_i, rst_i          clock, synchronous active-high reset
//             bus (slave modport)   requester, response and SRAM signals
//             stat_conflict_o       cycles with >=2 requests (stats build)
//             stat_grants_o         per-port grant counts    (stats build)
//  Options  : define SOC_MEM_ARB_STATS_EN to add the saturating counters.
//  Revision : 1.0  initial release
// ============================================================================
module soc_shared_mem_arb #(
    parameter int          NumPorts     = 2,
    parameter int          Width        = 32,
    parameter int          Depth        = 1 << 20,
    parameter logic [31:0] RelocateBase = 32'h8000_0000,
    parameter int          Latency      = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    soc_shared_mem_arb_if.slave       bus
`ifdef SOC_MEM_ARB_STATS_EN
    ,
    output logic [31:0]               stat_conflict_o,
    output logic [NumPorts-1:0][31:0] stat_grants_o
`endif
);
    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    // ---------------- arbitration ----------------
    logic [PW-1:0] rr_q, rr_d;
    logic          gnt_any;
    logic [PW-1:0] win;

    // Two passes: ports at/above the pointer first, then wrap to port 0.
    always_comb begin
        gnt_any = 1'b0;
        win     = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (!gnt_any && bus.req_i[i] && (i >= int'(rr_q))) begin
                gnt_any = 1'b1;
                win     = PW'(i);
            end
        end
        for (int i = 0; i < NumPorts; i++) begin
            if (!gnt_any && bus.req_i[i]) begin
                gnt_any = 1'b1;
                win     = PW'(i);
            end
        end
        // No grants while reset is held, so nothing enters the pipeline.
        if (rst_i) begin
            gnt_any = 1'b0;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt_any) begin
            rr_d = (int'(win) == NumPorts - 1) ? '0 : win + PW'(1);
        end
    end

    always_comb begin
        bus.gnt_o = '0;
        for (int i = 0; i < NumPorts; i++) begin
            bus.gnt_o[i] = gnt_any && (win == PW'(i));
        end
    end

    // ---------------- address decode ----------------
    logic [31:0] sel_addr;
    logic [31:0] off;
    logic [29:0] word;
    logic        in_range;
    logic        unused_off;

    assign sel_addr   = bus.addr_i[win];
    assign off        = sel_addr - RelocateBase;
    assign word       = off[31:2];
    assign in_range   = (sel_addr >= RelocateBase) && ({2'b00, word} < 32'(Depth));
    assign unused_off = ^off[1:0];   // byte offset within a word is ignored

    assign bus.mem_req_o   = gnt_any && in_range;
    assign bus.mem_we_o    = bus.mem_req_o && bus.we_i[win];
    assign bus.mem_addr_o  = word[AW-1:0];
    assign bus.mem_wdata_o = bus.wdata_i[win];
    assign bus.mem_wmask_o = bus.strb_i[win];

    // ---------------- response pipeline ----------------
    logic          s0_valid_q, s0_valid_d;
    logic [PW-1:0] s0_port_q, s0_port_d;
    logic          s0_read_q, s0_read_d;
    logic          s0_err_q, s0_err_d;

    always_comb begin
        s0_valid_d = gnt_any;
        s0_port_d  = win;
        s0_read_d  = !bus.we_i[win];
        s0_err_d   = !in_range;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            s0_valid_q <= 1'b0;
            s0_port_q  <= '0;
            s0_read_q  <= 1'b0;
            s0_err_q   <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            s0_valid_q <= s0_valid_d;
            s0_port_q  <= s0_port_d;
            s0_read_q  <= s0_read_d;
            s0_err_q   <= s0_err_d;
        end
    end

    // Stage 1 merges metadata with SRAM data; writes and errors return zero.
    logic             s1_valid;
    logic [PW-1:0]    s1_port;
    logic             s1_err;
    logic [Width-1:0] s1_data;

    always_comb begin
        s1_valid = s0_valid_q;
        s1_port  = s0_port_q;
        s1_err   = s0_valid_q && s0_err_q;
        s1_data  = (s0_valid_q && s0_read_q && !s0_err_q) ? bus.mem_rdata_i : '0;
    end

    logic             out_valid;
    logic [PW-1:0]    out_port;
    logic             out_err;
    logic [Width-1:0] out_data;

    generate
        if (Latency > 1) begin : g_pipe
            localparam int NS = Latency - 1;
            logic [NS-1:0]    vld_q, vld_d;
            logic [NS-1:0]    err_q, err_d;
            logic [PW-1:0]    port_q [NS];
            logic [PW-1:0]    port_d [NS];
            logic [Width-1:0] data_q [NS];
            logic [Width-1:0] data_d [NS];

            always_comb begin
                vld_d[0]  = s1_valid;
                err_d[0]  = s1_err;
                port_d[0] = s1_port;
                data_d[0] = s1_data;
                for (int s = 1; s < NS; s++) begin
                    vld_d[s]  = vld_q[s-1];
                    err_d[s]  = err_q[s-1];
                    port_d[s] = port_q[s-1];
                    data_d[s] = data_q[s-1];
                end
            end

            // Only the valid bits need reset; payload is qualified by them.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    vld_q <= '0;
                end else begin
                    vld_q <= vld_d;
                end
                err_q  <= err_d;
                port_q <= port_d;
                data_q <= data_d;
            end

            assign out_valid = vld_q[NS-1];
            assign out_err   = err_q[NS-1];
            assign out_port  = port_q[NS-1];
            assign out_data  = data_q[NS-1];
        end else begin : g_direct
            assign out_valid = s1_valid;
            assign out_err   = s1_err;
            assign out_port  = s1_port;
            assign out_data  = s1_data;
        end
    endgenerate

    // Steer the response to its port; all other ports read back zero.
    always_comb begin
        bus.rvalid_o = '0;
        bus.err_o    = '0;
        bus.rdata_o  = '0;
        if (out_valid && !rst_i) begin
            bus.rvalid_o[out_port] = 1'b1;
            bus.err_o[out_port]    = out_err;
            bus.rdata_o[out_port]  = out_data;
        end
    end

`ifdef SOC_MEM_ARB_STATS_EN
    // ---------------- statistics ----------------
    logic [31:0]               conflict_q, conflict_d;
    logic [NumPorts-1:0][31:0] grants_q, grants_d;

    always_comb begin
        conflict_d = conflict_q;
        if (($countones(bus.req_i) >= 2) && (conflict_q != '1)) begin
            conflict_d = conflict_q + 32'd1;
        end
        grants_d = grants_q;
        for (int i = 0; i < NumPorts; i++) begin
            if (bus.gnt_o[i] && (grants_q[i] != '1)) begin
                grants_d[i] = grants_q[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            conflict_q <= '0;
            grants_q   <= '0;
        end else begin
            conflict_q <= conflict_d;
            grants_q   <= grants_d;
        end
    end

    assign stat_conflict_o = conflict_q;
    assign stat_grants_o   = grants_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_soc_shared_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_soc_shared_mem_arb
//  Purpose  : Randomised scoreboard bench for soc_shared_mem_arb
//             (3 ports, 64-word SRAM, Latency 3). A reference model predicts
//             grants, SRAM traffic and responses; a separate monitor pops
//             expected responses whenever the DUT raises rvalid.
//  Revision : 1.0  initial release
// ============================================================================
module tb_soc_shared_mem_arb;
    localparam int          N    = 3;
    localparam int          W    = 32;
    localparam int          D    = 64;
    localparam int          LAT  = 3;
    localparam int          AW   = $clog2(D);
    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        int          port;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        logic [31:0] strb;
    } txn_t;

    typedef struct {
        int          port;
        logic [31:0] data;
        bit          err;
        int          due;
    } exp_t;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    bit   preload = 1'b1;
    bit   rst_nx  = 1'b1;
    bit   pre_nx  = 1'b1;
    int   cyc     = 0;
    int   tests   = 0;
    int   fails   = 0;
    int   rate    = 0;
    int   ptr     = 0;
    int   conf_cnt = 0;
    int   gnt_cnt [N];
    bit   act [N];
    txn_t cur [N];
    txn_t dq [$];
    exp_t sbq [$];
    exp_t mon_e;
    logic [31:0] mon_idle;
    logic [31:0] ref_mem [D];
    logic [31:0] sram [D];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    soc_shared_mem_arb_if #(.NumPorts(N), .Width(W), .AW(AW)) bus ();

`ifdef SOC_MEM_ARB_STATS_EN
    logic [31:0]        stat_conflict;
    logic [N-1:0][31:0] stat_grants;
`endif

    soc_shared_mem_arb #(
        .NumPorts    (N),
        .Width       (W),
        .Depth       (D),
        .RelocateBase(BASE),
        .Latency     (LAT)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .bus            (bus)
`ifdef SOC_MEM_ARB_STATS_EN
        ,
        .stat_conflict_o(stat_conflict),
        .stat_grants_o  (stat_grants)
`endif
    );

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
    endfunction

    // Behavioural SRAM: read data appears the cycle after the request;
    // garbage otherwise so that ungated data paths show up.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < D; i++) sram[i] <= init_word(i);
        end
        if (bus.mem_req_o) begin
            bus.mem_rdata_i <= sram[bus.mem_addr_o];
            if (bus.mem_we_o)
                sram[bus.mem_addr_o] <= (sram[bus.mem_addr_o] & ~bus.mem_wmask_o) |
                                        (bus.mem_wdata_o & bus.mem_wmask_o);
        end else begin
            bus.mem_rdata_i <= $urandom();
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    function automatic txn_t rand_txn(int p);
        txn_t t;
        int   r;
        r      = int'($urandom_range(0, 9));
        t.port = p;
        case (r)
            0:       t.addr = 32'h7FFF_FFFC;
            1:       t.addr = BASE + 32'(4 * D);
            2:       t.addr = $urandom();
            default: t.addr = BASE + 32'(4 * $urandom_range(0, D - 1)) + 32'($urandom_range(0, 3));
        endcase
        t.we    = ($urandom_range(0, 1) == 1);
        t.wdata = $urandom();
        t.strb  = $urandom();
        return t;
    endfunction

    function automatic bit any_act();
        for (int p = 0; p < N; p++) if (act[p]) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: round robin from ptr, relocation, bitwise writes.
    task automatic model_check();
        int           g;
        int           nreq;
        int unsigned  w;
        logic [31:0]  off;
        bit           inr;
        logic [N-1:0] eg;
        exp_t         e;
        if (rst) begin
            chk("gnt_in_reset", 64'(bus.gnt_o), 64'd0);
            chk("mem_req_we_in_reset", 64'({bus.mem_req_o, bus.mem_we_o}), 64'd0);
            sbq.delete();
            ptr      = 0;
            conf_cnt = 0;
            for (int p = 0; p < N; p++) gnt_cnt[p] = 0;
            return;
        end
        g    = -1;
        nreq = 0;
        for (int k = 0; k < N; k++) begin
            if (act[k]) nreq++;
            if (g < 0 && act[(ptr + k) % N]) g = (ptr + k) % N;
        end
        if (nreq >= 2) conf_cnt++;
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("gnt", 64'(bus.gnt_o), 64'(eg));
        if (g < 0) begin
            chk("mem_idle", 64'({bus.mem_req_o, bus.mem_we_o}), 64'd0);
            return;
        end
        off = cur[g].addr - BASE;
        w   = off >> 2;
        inr = (cur[g].addr >= BASE) && (w < D);
        chk("mem_req_we", 64'({bus.mem_req_o, bus.mem_we_o}), inr ? 64'({1'b1, cur[g].we}) : 64'd0);
        e.port = g;
        e.due  = cyc + LAT;
        if (!inr) begin
            e.data = '0;
            e.err  = 1'b1;
        end else begin
            chk("mem_addr", 64'(bus.mem_addr_o), 64'(w));
            e.err = 1'b0;
            if (cur[g].we) begin
                chk("mem_wdata", 64'(bus.mem_wdata_o), 64'(cur[g].wdata));
                chk("mem_wmask", 64'(bus.mem_wmask_o), 64'(cur[g].strb));
                ref_mem[w] = (ref_mem[w] & ~cur[g].strb) | (cur[g].wdata & cur[g].strb);
                e.data     = '0;
            end else begin
                e.data = ref_mem[w];
            end
        end
        sbq.push_back(e);
        act[g] = 1'b0;
        ptr    = (g + 1) % N;
        gnt_cnt[g]++;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        rst     = rst_nx;
        preload = pre_nx;
        for (int p = 0; p < N; p++) begin
            if (!act[p]) begin
                if (dq.size() > 0) begin
                    if (dq[0].port == p) begin
                        cur[p] = dq.pop_front();
                        act[p] = 1'b1;
                    end
                end else if (int'($urandom_range(0, 99)) < rate) begin
                    cur[p] = rand_txn(p);
                    act[p] = 1'b1;
                end
            end
            bus.req_i[p]   = act[p];
            bus.addr_i[p]  = cur[p].addr;
            bus.we_i[p]    = cur[p].we;
            bus.wdata_i[p] = cur[p].wdata;
            bus.strb_i[p]  = cur[p].strb;
        end
        @(negedge clk);
        model_check();
    endtask

    task automatic wait_idle(input int bound);
        for (int k = 0; k < bound && (dq.size() > 0 || any_act()); k++) step();
        if (dq.size() > 0 || any_act()) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: requests still pending after %0d cycles (required none)", bound);
        end
    endtask

    task automatic push(input int p, input logic [31:0] a, input bit we,
                        input logic [31:0] wd, input logic [31:0] sb);
        txn_t t;
        t.port  = p;
        t.addr  = a;
        t.we    = we;
        t.wdata = wd;
        t.strb  = sb;
        dq.push_back(t);
    endtask

    // Monitor: independent of stimulus, pops one expectation per rvalid.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rvalid_in_reset", 64'(bus.rvalid_o), 64'd0);
            end else begin
                while (sbq.size() > 0 && sbq[0].due < cyc) begin
                    mon_e = sbq.pop_front();
                    tests++;
                    fails++;
                    $display("FAIL rvalid_missing: port %0d got no response, required one at cycle %0d", mon_e.port, mon_e.due);
                end
                mon_idle = '0;
                for (int p = 0; p < N; p++) begin
                    if (bus.rvalid_o[p]) begin
                        if (sbq.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL rvalid_unexpected: port %0d rvalid 1, required 0 at cycle %0d", p, cyc);
                        end else begin
                            mon_e = sbq.pop_front();
                            chk("resp_port", 64'(p), 64'(mon_e.port));
                            chk("resp_rdata", 64'(bus.rdata_o[p]), 64'(mon_e.data));
                            chk("resp_err", 64'(bus.err_o[p]), 64'(mon_e.err));
                            chk("resp_cycle", 64'(cyc), 64'(mon_e.due));
                        end
                    end else begin
                        mon_idle = mon_idle | bus.rdata_o[p] | 32'(bus.err_o[p]);
                    end
                end
                chk("idle_port_outputs", 64'(mon_idle), 64'd0);
            end
        end
    end

    initial begin
        for (int i = 0; i < D; i++) ref_mem[i] = init_word(i);
        for (int p = 0; p < N; p++) begin
            act[p]     = 1'b0;
            gnt_cnt[p] = 0;
            cur[p]     = '{p, 32'h0, 1'b0, 32'h0, 32'h0};
        end
        bus.req_i   = '0;
        bus.addr_i  = '0;
        bus.we_i    = '0;
        bus.wdata_i = '0;
        bus.strb_i  = '0;

        // Reset with preload of the SRAM image
        rst_nx = 1'b1;
        pre_nx = 1'b1;
        repeat (3) step();
        rst_nx = 1'b0;
        pre_nx = 1'b0;
        step();

        // Directed: single read, bitwise write, out-of-range accesses
        push(0, 32'h8000_0040, 1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        push(1, 32'h8000_0040, 1'b0, 32'h0, 32'h0);
        push(0, 32'h8000_0000, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF);
        push(0, 32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 32'h0000_FF00);
        push(2, 32'h8000_0000, 1'b0, 32'h0, 32'h0);
        push(0, 32'h7FFF_FFFC, 1'b0, 32'h0, 32'h0);
        push(1, BASE + 32'(4 * D), 1'b0, 32'h0, 32'h0);
        push(0, 32'h7FFF_FFFC, 1'b1, 32'h0BAD_0BAD, 32'hFFFF_FFFF);
        push(1, BASE + 32'(4 * D), 1'b1, 32'h0BAD_0BAD, 32'hFFFF_FFFF);
        push(2, 32'h8000_0000, 1'b0, 32'h0, 32'h0);
        push(2, BASE + 32'(4 * (D - 1)), 1'b0, 32'h0, 32'h0);
        wait_idle(200);

        // Continuous contention, then mixed random traffic
        rate = 100;
        repeat (40) step();
        rate = 40;
        repeat (400) step();

        // Reset in the middle of a busy pipeline
        rate = 100;
        repeat (5) step();
        rst_nx = 1'b1;
        repeat (2) step();
        rst_nx = 1'b0;
        repeat (20) step();
        rate = 40;
        repeat (100) step();

        // Drain
        rate = 0;
        wait_idle(50);
        repeat (LAT + 2) step();
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

`ifdef SOC_MEM_ARB_STATS_EN
        chk("stat_conflict", 64'(stat_conflict), 64'(conf_cnt));
        for (int p = 0; p < N; p++) chk("stat_grants", 64'(stat_grants[p]), 64'(gnt_cnt[p]));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
